// File: rtl/ex_stage.sv
// RV32 execute stage: operand forwarding, single-cycle ALU, iterative mul/div FSM, EX/MEM register.
// Optional macro EX_MULDIV_EN enables ops 10-15; without it they retire as illegal with no write-back.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inValid,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  input  logic            ALUSrc,
  input  logic [3:0]      ALUOp,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic            memToReg,
  input  logic            regWrite,
  input  logic [4:0]      memWbRd,
  input  logic            memWbRegWrite,
  input  logic [XLEN-1:0] memWbResult,
  input  logic            flush,
  output logic            stall,
  output logic            exValid,
  output logic [XLEN-1:0] aluResult,
  output logic [XLEN-1:0] storeData,
  output logic [4:0]      rdOut,
  output logic            memReadOut,
  output logic            memWriteOut,
  output logic            memToRegOut,
  output logic            regWriteOut,
  output logic            illegalOp
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  logic            ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;
  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res, md_result, commit_res;
  logic [4:0]      shamt;
  logic            is_md, md_issue, md_busy, md_done, illegal, commit;

  // Loads in EX/MEM have no data yet, so only ALU results are forwarded from there.
  assign ex_hit_a = exValid && regWriteOut && !memToRegOut && (rdOut == rs1) && (rs1 != 5'd0);
  assign ex_hit_b = exValid && regWriteOut && !memToRegOut && (rdOut == rs2) && (rs2 != 5'd0);
  assign wb_hit_a = memWbRegWrite && (memWbRd == rs1) && (rs1 != 5'd0);
  assign wb_hit_b = memWbRegWrite && (memWbRd == rs2) && (rs2 != 5'd0);

  assign op_a  = ex_hit_a ? aluResult : (wb_hit_a ? memWbResult : rs1Data);
  assign fwd_b = ex_hit_b ? aluResult : (wb_hit_b ? memWbResult : rs2Data);
  assign op_b  = ALUSrc ? imm : fwd_b;
  assign shamt = op_b[4:0];
  assign is_md = ALUOp[3] & (ALUOp[2] | ALUOp[1]);

  always_comb begin
    alu_res = '0;
    case (ALUOp)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [4:0]      cnt;
  logic [3:0]      md_op;
  logic [XLEN-1:0] a_lat, b_lat, acc, lo, dvs;
  logic [XLEN-1:0] acc_next, lo_next, a_mag, b_mag, quo, rem;
  logic [XLEN:0]   mul_sum, div_rs, div_diff;
  logic            div_ge, issue_signed, md_is_mul, md_signed;

  assign md_issue = (state == S_IDLE) && inValid && is_md;
  assign md_busy  = (state == S_BUSY);
  assign md_done  = (state == S_DONE);
  assign illegal  = 1'b0;

  // Divides run on magnitudes; DIV/REM (even codes) are the signed forms.
  assign issue_signed = !ALUOp[0];
  assign a_mag = (issue_signed && op_a[XLEN-1]) ? -op_a : op_a;
  assign b_mag = (issue_signed && op_b[XLEN-1]) ? -op_b : op_b;
  assign md_is_mul = !md_op[2];
  assign md_signed = !md_op[0];

  // acc:lo is the 64-bit product for multiply, remainder:quotient for divide.
  always_comb begin
    mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, dvs} : '0);
    div_rs   = {acc, lo[XLEN-1]};
    div_ge   = div_rs >= {1'b0, dvs};
    div_diff = div_rs - {1'b0, dvs};
    if (md_is_mul) begin
      {acc_next, lo_next} = {mul_sum, lo[XLEN-1:1]};
    end else begin
      acc_next = div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0];
      lo_next  = {lo[XLEN-2:0], div_ge};
    end
  end

  always_comb begin
    quo = (md_signed && (a_lat[XLEN-1] ^ b_lat[XLEN-1])) ? -lo : lo;
    rem = (md_signed && a_lat[XLEN-1]) ? -acc : acc;
    md_result = '0;
    if (md_is_mul)              md_result = md_op[0] ? acc : lo;
    else if (b_lat == '0)       md_result = md_op[1] ? a_lat : '1;
    else                        md_result = md_op[1] ? rem : quo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
      md_op <= 4'd0;
      a_lat <= '0;
      b_lat <= '0;
      acc   <= '0;
      lo    <= '0;
      dvs   <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        S_IDLE: if (md_issue) begin
          state <= S_BUSY;
          cnt   <= 5'd0;
          md_op <= ALUOp;
          a_lat <= op_a;
          b_lat <= op_b;
          acc   <= '0;
          lo    <= ALUOp[2] ? a_mag : op_b;
          dvs   <= ALUOp[2] ? b_mag : op_a;
        end
        S_BUSY: begin
          acc <= acc_next;
          lo  <= lo_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign md_issue  = 1'b0;
  assign md_busy   = 1'b0;
  assign md_done   = 1'b0;
  assign illegal   = is_md;
  assign md_result = '0;
`endif

  assign stall      = !flush && (md_issue || md_busy);
  assign commit     = !flush && (md_done || (inValid && !md_issue && !md_busy));
  assign commit_res = md_done ? md_result : alu_res;

  // Anything that is not a commit writes a bubble; result and rd are left as they were.
  always_ff @(posedge clk) begin
    if (reset) begin
      exValid     <= 1'b0;
      aluResult   <= '0;
      storeData   <= '0;
      rdOut       <= 5'd0;
      memReadOut  <= 1'b0;
      memWriteOut <= 1'b0;
      memToRegOut <= 1'b0;
      regWriteOut <= 1'b0;
      illegalOp   <= 1'b0;
    end else if (commit) begin
      exValid     <= 1'b1;
      aluResult   <= commit_res;
      storeData   <= fwd_b;
      rdOut       <= rd;
      memReadOut  <= memRead;
      memWriteOut <= memWrite;
      memToRegOut <= memToReg;
      regWriteOut <= regWrite && !illegal;
      illegalOp   <= illegal;
    end else begin
      exValid     <= 1'b0;
      memReadOut  <= 1'b0;
      memWriteOut <= 1'b0;
      memToRegOut <= 1'b0;
      regWriteOut <= 1'b0;
      illegalOp   <= 1'b0;
    end
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the RV32 pipeline. Consumes the decoded operands and control bundle from the ID/EX register, forwards operands, computes single-cycle ALU results and multi-cycle multiply/divide results, and registers everything into the EX/MEM boundary. Multi-cycle operations run an iterative FSM and assert `stall` so that upstream holds the ID/EX contents.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk` input 1 rising-edge clock.
- `reset` input 1 synchronous, active-high reset.
- `inValid` input 1 ID/EX holds a live instruction; 0 means a bubble.
- `rs1`, `rs2`, `rd` input 5 each: register indices from ID/EX.
- `imm`, `rs1Data`, `rs2Data` input 32 each: immediate and register-file operands.
- `ALUSrc` input 1 selects operand B: 1 = `imm`, 0 = forwarded rs2.
- `ALUOp` input 4 operation code.
- `memRead`, `memWrite`, `memToReg`, `regWrite` input 1 each: control passed through to MEM/WB.
- `memWbRd` input 5, `memWbRegWrite` input 1, `memWbResult` input 32: MEM/WB forwarding source.
- `flush` input 1 kills the in-flight instruction.
- `stall` output 1 holds IF/ID and ID/EX; combinational.
- `exValid` output 1 EX/MEM holds a live instruction.
- `aluResult`, `storeData` output 32 each: result and forwarded rs2 value for stores.
- `rdOut` output 5, plus `memReadOut`, `memWriteOut`, `memToRegOut`, `regWriteOut` output 1 each: EX/MEM control.
- `illegalOp` output 1 registered with the instruction when its op is not supported.

## Operation
- ALUOp codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL (low 32 bits), 11 MULHU, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- Shift amounts use B[4:0]. SLT/SLTU produce 0 or 1.
- Forwarding for each of rs1 and rs2:
  - From EX/MEM when `exValid && regWriteOut && !memToRegOut && rdOut==rsX && rsX!=0`.
  - Otherwise from MEM/WB when `memWbRegWrite && memWbRd==rsX && rsX!=0`.
  - Otherwise from the register-file data.
  - EX/MEM takes priority over MEM/WB. x0 is never forwarded.
- FSM states:
  - IDLE: an `inValid` op of 10–15 asserts `stall`. At the clock edge the FSM latches the forwarded A and B and moves to BUSY with `cnt=0`. All other ops complete in one cycle.
  - BUSY: one shift-add step (multiply) or one restoring-divide step per cycle. `stall=1` throughout. When `cnt==31` the FSM moves to DONE.
  - DONE: `stall=0`. The clock edge writes the result to EX/MEM and the FSM returns to IDLE.
- Signed divide: operate on magnitudes, then fix signs. The quotient sign is sign(A) XOR sign(B); the remainder takes the sign of A.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = A.
- Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- The latched operands are used for the whole operation, so forwarding sources may change while stalled without effect.
- `flush` has priority over everything: FSM goes to IDLE, `exValid` drops to 0 at the next edge, and `stall` drops to 0 in the same cycle.

## Timing
- Reset: every output register is 0 (`exValid`, `aluResult`, `storeData`, `rdOut`, all control outs, `illegalOp`). FSM is IDLE, `cnt=0`, `stall=0`.
- Reset in the middle of BUSY aborts the operation with no result.
- Single-cycle op: accepted at edge N, visible on outputs after edge N. Throughput is one per cycle.
- Multi-cycle op: `stall` is high for 33 cycles (IDLE detect plus 32 BUSY cycles). The DONE cycle is the 34th, and the result appears after the 34th edge.
- While `stall=1`, each edge writes a bubble into EX/MEM (`exValid=0`, `regWriteOut=0`, `memWriteOut=0`, `memReadOut=0`).
- `inValid=0`: a bubble is written; `aluResult` and `rdOut` keep their previous values.
- A multi-cycle op immediately following another issues from IDLE on the cycle after DONE, with no extra gap.

## Configuration
- `EX_MULDIV_EN` defined: ops 10–15 are executed as described above.
- `EX_MULDIV_EN` undefined:
  - Ops 10–15 complete in one cycle with `aluResult=0` and `illegalOp=1`.
  - `regWriteOut` is forced to 0, the FSM is absent, and `stall` is tied to 0.

## Test plan
- Reset with outputs dirty → all outputs 0 after one edge; `stall=0`.
- ADD 5 + (−3) followed by a dependent SUB using rd → `aluResult` 2, then the EX/MEM-forwarded value is used with no stall.
- rd=x0 with regWrite, and rs1=x0 in the next instruction → no forward; the operand is the rs1Data value.
- DIV 0x80000000 / 0xFFFFFFFF, then REMU 7 / 0 → 0x80000000 after 34 cycles with `stall` high for 33; then 7.
- MUL 0xFFFF × 0x10001 with `flush` at BUSY cycle 10 → `stall` drops, no result is written, and the next ADD completes in 1 cycle.
- With `EX_MULDIV_EN` undefined, issue MULHU → `illegalOp=1`, `regWriteOut=0`, `stall` never asserted.
